// File: rtl/addr_decoder_n.sv
// Serial-bus address decoder: LSB-first device address, slave select/routing, one parked split.
// Optional WAIT watchdog enabled by defining ADDR_DEC_TIMEOUT_EN.
module addr_decoder_n #(
  parameter int NUM_SLAVES = 3,
  parameter int DEV_ADDR_WIDTH = 4,
  parameter int SEL_WIDTH = 2,
  parameter logic [NUM_SLAVES-1:0] SPLIT_MASK = 'b100
`ifdef ADDR_DEC_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  mwdata,
  input  logic                  mvalid,
  input  logic                  ssplit,
  input  logic                  split_grant,
  input  logic [NUM_SLAVES-1:0] sready,
  output logic [NUM_SLAVES-1:0] mvalid_s,
  output logic [SEL_WIDTH-1:0]  ssel,
  output logic                  ack,
  output logic                  nack,
  output logic                  split_pend,
  output logic                  timeout
);

  // state   | meaning
  // IDLE    | bus free; waits for mvalid or a split resume
  // ADDR    | shifting in address bits 1..DEV_ADDR_WIDTH-1
  // CONNECT | single decision cycle: ack or nack
  // WAIT    | connected to ssel until completion, split or watchdog
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ADDR    = 2'd1;
  localparam logic [1:0] CONNECT = 2'd2;
  localparam logic [1:0] WAIT    = 2'd3;

  localparam int CW = (DEV_ADDR_WIDTH > 2) ? $clog2(DEV_ADDR_WIDTH) : 1;
  localparam logic [CW-1:0] BIT_LOAD = CW'(DEV_ADDR_WIDTH - 2);

  logic [1:0]                state_q, state_d;
  logic [DEV_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [SEL_WIDTH-1:0]      ssel_q, ssel_d;
  logic [SEL_WIDTH-1:0]      split_addr_q, split_addr_d;
  logic                      split_pend_q, split_pend_d;
  logic                      busy_seen_q, busy_seen_d;

  logic addr_in_range, addr_ready, sel_ready, sel_can_split;
  logic in_connect, in_wait, addr_valid, split_take, wait_done, enter_wait;

  always_comb begin
    addr_in_range = 1'b0;
    addr_ready    = 1'b0;
    sel_ready     = 1'b0;
    sel_can_split = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (int'(addr_q) == k) begin
        addr_in_range = 1'b1;
        addr_ready    = sready[k];
      end
      if (int'(ssel_q) == k) begin
        sel_ready     = sready[k];
        sel_can_split = SPLIT_MASK[k];
      end
    end
  end

  assign in_connect = (state_q == CONNECT);
  assign in_wait    = (state_q == WAIT);
  // The parked slave is refused so a second split can never be requested.
  assign addr_valid = addr_in_range & addr_ready &
                      ~(split_pend_q & (int'(addr_q) == int'(split_addr_q)));
  assign split_take = in_wait & ssplit & sel_can_split;
  assign wait_done  = in_wait & sel_ready & busy_seen_q;

  assign ack        = in_connect & addr_valid;
  assign nack       = in_connect & ~addr_valid;
  assign ssel       = ssel_q;
  assign split_pend = split_pend_q;

`ifdef ADDR_DEC_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] WCNT_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wcnt_q, wcnt_d;
  assign timeout = in_wait & ~split_take & ~wait_done & (wcnt_q == WCNT_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    mvalid_s = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (int'(ssel_q) == k) mvalid_s[k] = mvalid & (ack | in_wait);
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    bit_cnt_d    = bit_cnt_q;
    ssel_d       = ssel_q;
    split_addr_d = split_addr_q;
    split_pend_d = split_pend_q;
    busy_seen_d  = busy_seen_q;
    enter_wait   = 1'b0;
`ifdef ADDR_DEC_TIMEOUT_EN
    wcnt_d       = wcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (split_grant && split_pend_q) begin
          state_d      = WAIT;
          ssel_d       = split_addr_q;
          split_pend_d = 1'b0;
          enter_wait   = 1'b1;
        end else if (mvalid) begin
          state_d   = ADDR;
          addr_d    = {mwdata, addr_q[DEV_ADDR_WIDTH-1:1]};
          bit_cnt_d = BIT_LOAD;
        end
      end
      ADDR: begin
        // Bits enter at the MSB and shift down, so bit 0 lands in place last.
        addr_d = {mwdata, addr_q[DEV_ADDR_WIDTH-1:1]};
        if (bit_cnt_q == '0) begin
          state_d = CONNECT;
          ssel_d  = SEL_WIDTH'(addr_d);
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      CONNECT: begin
        if (addr_valid) begin
          state_d    = WAIT;
          enter_wait = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!sel_ready) busy_seen_d = 1'b1;
        if (split_take) begin
          split_addr_d = ssel_q;
          split_pend_d = 1'b1;
          state_d      = IDLE;
        end else if (wait_done) begin
          state_d = IDLE;
        end
`ifdef ADDR_DEC_TIMEOUT_EN
        else if (timeout) begin
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (enter_wait) begin
      busy_seen_d = 1'b0;
`ifdef ADDR_DEC_TIMEOUT_EN
      wcnt_d      = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      bit_cnt_q    <= '0;
      ssel_q       <= '0;
      split_addr_q <= '0;
      split_pend_q <= 1'b0;
      busy_seen_q  <= 1'b0;
`ifdef ADDR_DEC_TIMEOUT_EN
      wcnt_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      bit_cnt_q    <= bit_cnt_d;
      ssel_q       <= ssel_d;
      split_addr_q <= split_addr_d;
      split_pend_q <= split_pend_d;
      busy_seen_q  <= busy_seen_d;
`ifdef ADDR_DEC_TIMEOUT_EN
      wcnt_q       <= wcnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_addr_decoder_n.sv
// Self-checking bench for addr_decoder_n: vector table plus watchdog/long-wait sequence.
module tb_addr_decoder_n;

  logic       clk = 1'b0;
  logic       rstn, mwdata, mvalid, ssplit, split_grant;
  logic [2:0] sready;
  logic [2:0] mvalid_s;
  logic [1:0] ssel;
  logic       ack, nack, split_pend, timeout;

`ifdef ADDR_DEC_TIMEOUT_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif

  addr_decoder_n #(
    .NUM_SLAVES(3), .DEV_ADDR_WIDTH(4), .SEL_WIDTH(2), .SPLIT_MASK(3'b100)
`ifdef ADDR_DEC_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .rstn(rstn), .mwdata(mwdata), .mvalid(mvalid), .ssplit(ssplit),
    .split_grant(split_grant), .sready(sready), .mvalid_s(mvalid_s), .ssel(ssel),
    .ack(ack), .nack(nack), .split_pend(split_pend), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rstn, mvalid, mwdata, ssplit, grant;
    logic [2:0] sready;
    logic [2:0] ms;
    logic [1:0] ssel;
    logic       ack, nack, sp, to;
  } vec_t;

  typedef struct {
    logic [2:0] ms;
    logic [1:0] ssel;
    logic       ack, nack, sp, to;
    int         tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   tag_cnt = 0;

  function automatic vec_t mk(input logic r, input logic mv, input logic d, input logic sp_in,
                              input logic g, input logic [2:0] rdy, input logic [2:0] ms,
                              input logic [1:0] sel, input logic a, input logic n,
                              input logic sp, input logic to = 1'b0);
    vec_t v;
    v.rstn = r; v.mvalid = mv; v.mwdata = d; v.ssplit = sp_in; v.grant = g; v.sready = rdy;
    v.ms = ms; v.ssel = sel; v.ack = a; v.nack = n; v.sp = sp; v.to = to;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rstn = v.rstn; mvalid = v.mvalid; mwdata = v.mwdata; ssplit = v.ssplit;
    split_grant = v.grant; sready = v.sready;
    e.ms = v.ms; e.ssel = v.ssel; e.ack = v.ack; e.nack = v.nack; e.sp = v.sp; e.to = v.to;
    e.tag = tag_cnt;
    tag_cnt++;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int tag, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("mvalid_s", e.tag, {1'b0, mvalid_s}, {1'b0, e.ms});
      chk("ssel", e.tag, {2'b0, ssel}, {2'b0, e.ssel});
      chk("ack", e.tag, {3'b0, ack}, {3'b0, e.ack});
      chk("nack", e.tag, {3'b0, nack}, {3'b0, e.nack});
      chk("split_pend", e.tag, {3'b0, split_pend}, {3'b0, e.sp});
      chk("timeout", e.tag, {3'b0, timeout}, {3'b0, e.to});
    end
  end

  initial begin
    rstn = 1'b0; mvalid = 1'b0; mwdata = 1'b0; ssplit = 1'b0; split_grant = 1'b0; sready = 3'b111;
    repeat (2) @(posedge clk);

    // reset
    vecs.push_back(mk(0,0,0,0,0,7, 0,0,0,0,0));
    // address 1 -> ack in 4th cycle after first bit, routed to slave 1
    vecs.push_back(mk(1,1,1,0,0,7, 0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 3'b010,1,1,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 3'b010,1,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,5, 0,1,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 3'b010,1,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,7, 0,1,0,0,0));
    // address 5 -> nack, ssel takes truncated value 1
    vecs.push_back(mk(1,1,1,0,0,7, 0,1,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 0,1,0,0,0));
    vecs.push_back(mk(1,1,1,0,0,7, 0,1,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 0,1,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 0,1,0,1,0));
    // address 3 -> nack, ssel=3, no routing with mvalid high
    vecs.push_back(mk(1,1,1,0,0,7, 0,1,0,0,0));
    vecs.push_back(mk(1,1,1,0,0,7, 0,1,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 0,1,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 0,1,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 0,3,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,7, 0,3,0,0,0));
    // address 2, split, re-access nacked, grant resumes
    vecs.push_back(mk(1,1,0,0,0,7, 0,3,0,0,0));
    vecs.push_back(mk(1,1,1,0,0,7, 0,3,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 0,3,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 0,3,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 3'b100,2,1,0,0));
    vecs.push_back(mk(1,1,0,1,0,7, 3'b100,2,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 0,2,0,0,1));
    vecs.push_back(mk(1,1,1,0,0,7, 0,2,0,0,1));
    vecs.push_back(mk(1,1,0,0,0,7, 0,2,0,0,1));
    vecs.push_back(mk(1,1,0,0,0,7, 0,2,0,0,1));
    vecs.push_back(mk(1,1,0,0,0,7, 0,2,0,1,1));
    vecs.push_back(mk(1,0,0,0,1,7, 0,2,0,0,1));
    vecs.push_back(mk(1,1,0,0,0,7, 3'b100,2,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,3, 0,2,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,7, 0,2,0,0,0));
    // address 0, ssplit ignored, exit after busy->ready
    vecs.push_back(mk(1,1,0,0,0,7, 0,2,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 0,2,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 0,2,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 0,2,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 3'b001,0,1,0,0));
    vecs.push_back(mk(1,1,0,1,0,7, 3'b001,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 3'b001,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,6, 3'b001,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,7, 0,0,0,0,0));
    // park split at 2, nack address 3, then grant beats mvalid
    vecs.push_back(mk(1,1,0,0,0,7, 0,0,0,0,0));
    vecs.push_back(mk(1,1,1,0,0,7, 0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 3'b100,2,1,0,0));
    vecs.push_back(mk(1,0,0,1,0,7, 0,2,0,0,0));
    vecs.push_back(mk(1,1,1,0,0,7, 0,2,0,0,1));
    vecs.push_back(mk(1,1,1,0,0,7, 0,2,0,0,1));
    vecs.push_back(mk(1,1,0,0,0,7, 0,2,0,0,1));
    vecs.push_back(mk(1,1,0,0,0,7, 0,2,0,0,1));
    vecs.push_back(mk(1,1,0,0,0,7, 0,3,0,1,1));
    vecs.push_back(mk(1,1,1,0,1,7, 0,3,0,0,1));
    vecs.push_back(mk(1,1,0,0,0,7, 3'b100,2,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 3'b100,2,0,0,0));
    // reset in WAIT
    vecs.push_back(mk(0,1,0,0,0,7, 3'b100,2,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,7, 0,0,0,0,0));
    // reset discards a parked split; later grant ignored
    vecs.push_back(mk(1,1,0,0,0,7, 0,0,0,0,0));
    vecs.push_back(mk(1,1,1,0,0,7, 0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 3'b100,2,1,0,0));
    vecs.push_back(mk(1,0,0,1,0,7, 0,2,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,7, 0,2,0,0,1));
    vecs.push_back(mk(1,0,0,0,1,7, 0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,7, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,7, 0,0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);

    // long WAIT with slave 1 held busy: watchdog at the 16th WAIT cycle, or indefinite wait
    drive(mk(1,1,1,0,0,7, 0,0,0,0,0));
    drive(mk(1,1,0,0,0,7, 0,0,0,0,0));
    drive(mk(1,1,0,0,0,7, 0,0,0,0,0));
    drive(mk(1,1,0,0,0,7, 0,0,0,0,0));
    drive(mk(1,1,0,0,0,7, 3'b010,1,1,0,0));
    for (int i = 0; i < 40; i++) begin
      if (TE && i > 15) drive(mk(1,0,0,0,0,5, 0,1,0,0,0,0));
      else              drive(mk(1,1,0,0,0,5, 3'b010,1,0,0,0,(TE && i == 15)));
    end
    drive(mk(1,0,0,0,0,7, 0,1,0,0,0));
    drive(mk(1,0,0,0,0,7, 0,1,0,0,0));

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
